// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: Funct codes, FSM states, default widths.
// Also consumed by the ALU control decoder so both sides agree on Funct encodings.
package alu_pkg;

    localparam int unsigned ALU_DATA_W  = 32;
    localparam int unsigned ALU_SHAMT_W = 5;

    localparam logic [5:0] FUNCT_ADDU = 6'b001001;
    localparam logic [5:0] FUNCT_SUBU = 6'b001010;
    localparam logic [5:0] FUNCT_AND  = 6'b010001;
    localparam logic [5:0] FUNCT_SLL  = 6'b100001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } alu_state_e;

    function automatic logic is_sll(input logic [5:0] funct);
        return funct == FUNCT_SLL;
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// Left shifter for sll with start/done handshake. SLL_BARREL_EN selects a single-cycle
// barrel shift; otherwise an iterative one-bit-per-cycle shifter is built.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = ALU_DATA_W,
    parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
`ifndef SLL_BARREL_EN
    input  logic               clk,
    input  logic               rst,
`endif
    input  logic               start,
    input  logic [DATA_W-1:0]  src,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done_c,
    output logic [DATA_W-1:0]  result_c
);

`ifdef SLL_BARREL_EN

    always_comb begin
        done_c   = start;
        result_c = src << shamt;
    end

`else

    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Load on start, then shift one bit per cycle until the count is exhausted.
    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (start) begin
            shreg_d = src;
            cnt_d   = shamt;
        end else if (cnt_q != '0) begin
            shreg_d = shreg_q << 1;
            cnt_d   = cnt_q - SHAMT_W'(1);
        end
    end

    // The last shift step is presented combinationally so the top can register it directly.
    always_comb begin
        done_c   = (cnt_q == SHAMT_W'(1));
        result_c = shreg_q << 1;
    end

`endif

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: addu/subu/AND in one cycle, sll via alu_shifter, valid/ready result.
// Build option SLL_BARREL_EN: single-cycle sll instead of the iterative shifter.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = ALU_DATA_W,
    parameter int unsigned SHAMT_W = ALU_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         funct,
    input  logic [DATA_W-1:0]  src1,
    input  logic [DATA_W-1:0]  src2,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  result,
    output logic               zero,
    output logic               busy
);

    alu_state_e        state_q, state_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              zero_q, zero_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic              accept_c;
    logic              shift_start_c;
    logic              shift_done_c;
    logic [DATA_W-1:0] shift_result_c;
    logic [DATA_W-1:0] alu_c;

    always_comb begin
        accept_c      = in_valid && (state_q == ST_IDLE);
        shift_start_c = accept_c && is_sll(funct) && (shamt != '0);
    end

    // Single-cycle ops; unknown codes (including the decoder default 0) give 0.
    always_comb begin
        alu_c = '0;
        case (funct)
            FUNCT_ADDU: alu_c = src1 + src2;
            FUNCT_SUBU: alu_c = src1 - src2;
            FUNCT_AND:  alu_c = src1 & src2;
            default:    alu_c = '0;
        endcase
    end

    alu_shifter #(
        .DATA_W  (DATA_W),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
`ifndef SLL_BARREL_EN
        .clk      (clk),
        .rst      (rst),
`endif
        .start    (shift_start_c),
        .src      (src2),
        .shamt    (shamt),
        .done_c   (shift_done_c),
        .result_c (shift_result_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (!is_sll(funct)) begin
                        result_d = alu_c;
                        state_d  = ST_HOLD;
                    end else if (shamt == '0) begin
                        result_d = src2;
                        state_d  = ST_HOLD;
                    end else if (shift_done_c) begin
                        result_d = shift_result_c;
                        state_d  = ST_HOLD;
                    end else begin
                        state_d  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (shift_done_c) begin
                    result_d = shift_result_c;
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Flags follow the registered value, so they are derived from the next state/result.
        zero_d      = (result_d == '0);
        out_valid_d = (state_d == ST_HOLD);
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: transaction-level model checked every cycle,
// plus hand-computed expectations for each directed vector.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [5:0]  funct = 6'd0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    alu_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .src1      (src1),
        .src2      (src2),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] spec_result(input logic [5:0] f, input logic [31:0] a,
                                                input logic [31:0] b, input logic [4:0] sh);
        case (f)
            6'b001001: return a + b;
            6'b001010: return a - b;
            6'b010001: return a & b;
            6'b100001: return b << sh;
            default:   return 32'd0;
        endcase
    endfunction

    function automatic int spec_latency(input logic [5:0] f, input logic [4:0] sh);
`ifdef SLL_BARREL_EN
        return 1;
`else
        return (f == 6'b100001 && sh != 5'd0) ? int'(sh) + 1 : 1;
`endif
    endfunction

    // Transaction model: one op in flight, result appears after its latency, held until taken.
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_res = 32'd0;
    logic [31:0] m_shown = 32'd0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_wait  = 0;
            m_shown = 32'd0;
        end else if (m_valid) begin
            if (out_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_shown = m_res;
            end
        end else if (in_valid) begin
            m_res  = spec_result(funct, src1, src2, shamt);
            m_wait = spec_latency(funct, shamt) - 1;
            m_busy = 1'b1;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_shown = m_res;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("mon_out_valid", 32'(out_valid), 32'(m_valid));
            chk("mon_in_ready",  32'(in_ready),  32'(!m_busy));
            chk("mon_busy",      32'(busy),      32'(m_busy));
            chk("mon_result",    result,         m_shown);
            chk("mon_zero",      32'(zero),      32'(m_shown == 32'd0));
        end
    end

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        @(negedge clk);
        funct = f; src1 = a; src2 = b; shamt = sh; in_valid = 1'b1;
        @(negedge clk);
        // Scramble operands after accept; the unit must have sampled them already.
        in_valid = 1'b0; funct = f ^ 6'h3f; src1 = ~a; src2 = ~b; shamt = ~sh;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"},  32'(lat),  32'(exp_lat));
        chk({name, "_res"},  result,    exp);
        chk({name, "_zero"}, 32'(zero), 32'(exp == 32'd0));
        @(negedge clk);
    endtask

    initial begin
        int sll_lat4;
        int sll_lat31;
`ifdef SLL_BARREL_EN
        sll_lat4  = 1;
        sll_lat31 = 1;
`else
        sll_lat4  = 5;
        sll_lat31 = 32;
`endif
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_result",    result,         32'd0);
        chk("rst_zero",      32'(zero),      32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        check_en = 1'b1;

        run_op("addu_wrap", 6'b001001, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1);
        run_op("subu_neg",  6'b001010, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1);
        run_op("and",       6'b010001, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00F0_1234, 1);
        run_op("sll4",      6'b100001, 32'hDEAD_BEEF, 32'h3, 5'd4, 32'h30, sll_lat4);
        run_op("sll31",     6'b100001, 32'h0, 32'h1, 5'd31, 32'h8000_0000, sll_lat31);
        run_op("sll0",      6'b100001, 32'h0, 32'h1234_ABCD, 5'd0, 32'h1234_ABCD, 1);
        run_op("funct0",    6'b000000, 32'h11, 32'h22, 5'd3, 32'h0, 1);
        run_op("funct0b",   6'b001011, 32'h11, 32'h22, 5'd3, 32'h0, 1);

        // Backpressure: result held while out_ready is low; new requests ignored.
        @(negedge clk);
        out_ready = 1'b0;
        funct = 6'b001001; src1 = 32'd2; src2 = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_valid",  32'(out_valid), 32'd1);
        chk("bp_result", result,         32'd5);
        for (int i = 0; i < 10; i++) begin
            funct = 6'b001010; src1 = 32'd100; src2 = 32'd1; in_valid = 1'b1;
            @(negedge clk);
            chk("bp_hold_result", result,          32'd5);
            chk("bp_hold_ready",  32'(in_ready),   32'd0);
            chk("bp_hold_valid",  32'(out_valid),  32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready),  32'd1);

        // Reset mid-shift discards the in-flight sll.
        @(negedge clk);
        funct = 6'b100001; src1 = 32'd0; src2 = 32'h1; shamt = 5'd20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_result",    result,         32'd0);
        chk("mid_rst_zero",      32'(zero),      32'd1);
        chk("mid_rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_addu", 6'b001001, 32'd2, 32'd3, 5'd0, 32'd5, 1);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule
